quadrature_encoder_emulator: RTL and testbench

QUADRATURE_ENCODER_EMULATOR -- requirements
Module: quadrature_encoder_emulator

---
 rtl/quad_enc_pkg.sv | 24 ++
 rtl/quadrature_phase_sequencer.sv | 33 +++
 rtl/quadrature_encoder_emulator.sv | 156 +++++++++++++++
 tb/tb_quadrature_encoder_emulator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/quad_enc_pkg.sv
// quad_enc_pkg: register map, CTRL bit indices, FSM states and quadrature phase table
// shared by quadrature_encoder_emulator and its phase sequencer.
package quad_enc_pkg;
    localparam logic [3:0] ADDR_CTRL     = 4'h0;
    localparam logic [3:0] ADDR_PERIOD   = 4'h1;
    localparam logic [3:0] ADDR_TARGET   = 4'h2;
    localparam logic [3:0] ADDR_POSITION = 4'h3;
    localparam logic [3:0] ADDR_CPR      = 4'h4;
    localparam logic [3:0] ADDR_STATUS   = 4'h5;
    localparam logic [3:0] ADDR_EDGES    = 4'h6;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_DIR  = 2;

    typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_e;

    // AB for phase 0..3, phase 0 in the low bits: 00 -> 10 -> 11 -> 01
    localparam logic [7:0] PHASE_SEQ = {2'b01, 2'b11, 2'b10, 2'b00};

    function automatic logic [1:0] phase_ab(input logic [1:0] p);
        return PHASE_SEQ[{p, 1'b0} +: 2];
    endfunction
endpackage

// File: rtl/quadrature_phase_sequencer.sv
// quadrature_phase_sequencer: 2-bit up/down phase stepper with registered A/B outputs
// decoded from the phase table so exactly one output toggles per step.
module quadrature_phase_sequencer
    import quad_enc_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic step_i,
    input  logic fwd_i,
    output logic a_o,
    output logic b_o
);
    logic [1:0] phase_q, phase_d;
    logic [1:0] ab_q, ab_d;

    always_comb begin
        phase_d = step_i ? (fwd_i ? phase_q + 2'd1 : phase_q - 2'd1) : phase_q;
        ab_d    = phase_ab(phase_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            ab_q    <= '0;
        end else begin
            phase_q <= phase_d;
            ab_q    <= ab_d;
        end
    end

    assign a_o = ab_q[1];
    assign b_o = ab_q[0];
endmodule

// File: rtl/quadrature_encoder_emulator.sv
// quadrature_encoder_emulator: Avalon-MM controlled A/B/I encoder emulator (velocity or position mode).
// Define QUAD_ENC_INDEX_EN to build the CPR register, revolution counter and index output I.
module quadrature_encoder_emulator
    import quad_enc_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        write,
    input  logic        read,
    input  logic [3:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        A,
    output logic        B,
    output logic        I,
    output logic        busy
);
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] period_q, period_d, target_q, target_d;
    logic [31:0] position_q, position_d, edges_q, edges_d, cnt_q, cnt_d;
    logic [31:0] pos_step;
    state_e      state_q, state_d;
    logic        wr_ctrl, wr_period, wr_target, wr_pos;
    logic        eligible, fwd, still, step, at_target;
    logic        unused_read;

    assign unused_read = read ^ (CLOCK_FREQ_HZ == 0);

    assign wr_ctrl   = write && address == ADDR_CTRL;
    assign wr_period = write && address == ADDR_PERIOD;
    assign wr_target = write && address == ADDR_TARGET;
    assign wr_pos    = write && address == ADDR_POSITION;

    // Motion decisions look only at registered values, never at this cycle's write
    assign at_target = position_q == target_q;
    assign eligible  = ctrl_q[CTRL_EN] && period_q != 0 && (!ctrl_q[CTRL_MODE] || !at_target);
    assign fwd       = ctrl_q[CTRL_MODE] ? $signed(target_q - position_q) > 0 : ctrl_q[CTRL_DIR];
    assign pos_step  = fwd ? position_q + 32'd1 : position_q - 32'd1;
    assign still     = !ctrl_q[CTRL_MODE] || pos_step != target_q;
    assign busy      = state_q == COUNT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_d = COUNT;
                    cnt_d   = period_q - 32'd1;
                end
            end
            COUNT: begin
                if (!eligible) begin
                    state_d = IDLE;
                end else if (cnt_q == 0) begin
                    step    = 1'b1;
                    cnt_d   = period_q - 32'd1;
                    state_d = still ? COUNT : IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ctrl_d     = wr_ctrl ? writedata[2:0] : ctrl_q;
        period_d   = wr_period ? writedata : period_q;
        target_d   = wr_target ? writedata : target_q;
        position_d = wr_pos ? writedata : step ? pos_step : position_q;
        edges_d    = step ? edges_q + 32'd1 : edges_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ctrl_q     <= '0;
            period_q   <= '0;
            target_q   <= '0;
            position_q <= '0;
            edges_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ctrl_q     <= ctrl_d;
            period_q   <= period_d;
            target_q   <= target_d;
            position_q <= position_d;
            edges_q    <= edges_d;
        end
    end

    quadrature_phase_sequencer u_seq (
        .clk    (clk),
        .reset_n(reset_n),
        .step_i (step),
        .fwd_i  (fwd),
        .a_o    (A),
        .b_o    (B)
    );

`ifdef QUAD_ENC_INDEX_EN
    logic [31:0] cpr_q, cpr_d, rev_q, rev_d;
    logic        idx_q, idx_d;
    logic        wr_cpr;

    assign wr_cpr = write && address == ADDR_CPR;

    // I is registered from next-state so it moves on the same clock as A/B
    always_comb begin
        cpr_d = wr_cpr ? writedata : cpr_q;
        rev_d = (wr_cpr || wr_pos) ? 32'd0 :
                !(step && cpr_q != 0) ? rev_q :
                fwd ? (rev_q == cpr_q - 32'd1 ? 32'd0 : rev_q + 32'd1) :
                      (rev_q == 0 ? cpr_q - 32'd1 : rev_q - 32'd1);
        idx_d = rev_d == 0 && cpr_d != 0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpr_q <= '0;
            rev_q <= '0;
            idx_q <= 1'b0;
        end else begin
            cpr_q <= cpr_d;
            rev_q <= rev_d;
            idx_q <= idx_d;
        end
    end

    assign I = idx_q;
`else
    assign I = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:     readdata = {29'd0, ctrl_q};
            ADDR_PERIOD:   readdata = period_q;
            ADDR_TARGET:   readdata = target_q;
            ADDR_POSITION: readdata = position_q;
`ifdef QUAD_ENC_INDEX_EN
            ADDR_CPR:      readdata = cpr_q;
`endif
            ADDR_STATUS:   readdata = {30'd0, at_target, busy};
            ADDR_EDGES:    readdata = edges_q;
            default:       readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// tb_quadrature_encoder_emulator: directed checks of timing, phase order, position mode,
// write collision, reset abort, wrap and index behaviour.
module tb_quadrature_encoder_emulator;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [3:0]  address = 4'h0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        A, B, I, busy;
    int          checks = 0;
    int          errors = 0;
    int          n;
    logic        ch;
    logic [1:0]  fwd_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0]  rev_seq [3] = '{2'b01, 2'b11, 2'b10};

    always #5 clk = ~clk;

    quadrature_encoder_emulator dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .write    (write),
        .read     (read),
        .address  (address),
        .writedata(writedata),
        .readdata (readdata),
        .A        (A),
        .B        (B),
        .I        (I),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        write = 1'b1;
        address = a;
        writedata = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic wait_ab(input int budget, output int cnt, output logic changed);
        logic [1:0] prev;
        prev = {A, B};
        cnt = 0;
        changed = 1'b0;
        while (!changed && cnt < budget) begin
            @(negedge clk);
            cnt++;
            changed = {A, B} != prev;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Test 1: reset state, then velocity forward with PERIOD=4
        do_reset();
        check("rst_ab", {30'd0, A, B}, 32'd0);
        check("rst_i", {31'd0, I}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rd_chk("rst_status", 4'h5, 32'd2);
        rd_chk("rst_ctrl", 4'h0, 32'd0);
        rd_chk("rst_edges", 4'h6, 32'd0);
        rd_chk("unmapped", 4'hF, 32'd0);
        wr(4'h1, 32'd4);
        wr(4'h0, 32'd5);
        for (int k = 0; k < 4; k++) begin
            wait_ab(20, n, ch);
            check("t1_gap", n, k == 0 ? 32'd5 : 32'd4);
            check("t1_ab", {30'd0, A, B}, {30'd0, fwd_seq[k]});
        end
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_i", {31'd0, I}, 32'd0);
        rd_chk("t1_pos", 4'h3, 32'd4);
        rd_chk("t1_edges", 4'h6, 32'd4);
        rd_chk("t1_ctrl", 4'h0, 32'd5);
        wr(4'h0, 32'd0);
        @(negedge clk);
        check("t1_stop_busy", {31'd0, busy}, 32'd0);
        wait_ab(10, n, ch);
        check("t1_hold", {31'd0, ch}, 32'd0);

        // Test 4: POSITION write on the exact edge cycle
        do_reset();
        wr(4'h1, 32'd4);
        wr(4'h0, 32'd5);
        wait_ab(20, n, ch);
        check("t4_first", n, 32'd5);
        repeat (3) @(negedge clk);
        wr(4'h3, 32'd100);
        check("t4_ab", {30'd0, A, B}, 32'b11);
        rd_chk("t4_pos", 4'h3, 32'd100);
        rd_chk("t4_edges", 4'h6, 32'd2);
        wr(4'h0, 32'd0);

        // Test 5: reset mid-COUNT
        do_reset();
        wr(4'h1, 32'd10);
        wr(4'h0, 32'd5);
        wait_ab(20, n, ch);
        check("t5_first", n, 32'd11);
        repeat (3) @(negedge clk);
        check("t5_busy_pre", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t5_ab", {30'd0, A, B}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_i", {31'd0, I}, 32'd0);
        rd_chk("t5_pos", 4'h3, 32'd0);
        rd_chk("t5_ctrl", 4'h0, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_ab(12, n, ch);
        check("t5_quiet", {31'd0, ch}, 32'd0);
        check("t5_busy_post", {31'd0, busy}, 32'd0);

        // Test 2: position mode toward TARGET=-3
        do_reset();
        wr(4'h2, 32'hFFFF_FFFD);
        wr(4'h1, 32'd2);
        wr(4'h0, 32'd3);
        for (int k = 0; k < 3; k++) begin
            wait_ab(20, n, ch);
            check("t2_gap", n, k == 0 ? 32'd3 : 32'd2);
            check("t2_ab", {30'd0, A, B}, {30'd0, rev_seq[k]});
        end
        check("t2_busy", {31'd0, busy}, 32'd0);
        rd_chk("t2_status", 4'h5, 32'd2);
        rd_chk("t2_pos", 4'h3, 32'hFFFF_FFFD);
        rd_chk("t2_edges", 4'h6, 32'd3);
        wait_ab(10, n, ch);
        check("t2_quiet", {31'd0, ch}, 32'd0);

        // Test 6: 32-bit wrap
        do_reset();
        wr(4'h3, 32'h7FFF_FFFF);
        wr(4'h1, 32'd3);
        wr(4'h0, 32'd5);
        wait_ab(20, n, ch);
        check("t6_first", n, 32'd4);
        rd_chk("t6_pos", 4'h3, 32'h8000_0000);
        wr(4'h0, 32'd0);

`ifdef QUAD_ENC_INDEX_EN
        // Test 3: index pulse with CPR=8
        do_reset();
        wr(4'h4, 32'd8);
        check("t3_i_init", {31'd0, I}, 32'd1);
        rd_chk("t3_cpr", 4'h4, 32'd8);
        wr(4'h1, 32'd8);
        wr(4'h0, 32'd5);
        for (int i = 1; i <= 16; i++) begin
            wait_ab(20, n, ch);
            check("t3_i_edge", {31'd0, I}, {31'd0, i % 8 == 0});
            if (i == 8) begin
                int hi;
                hi = 0;
                repeat (7) begin
                    @(negedge clk);
                    hi += int'(I);
                end
                check("t3_i_width", hi, 32'd7);
            end
        end
        wr(4'h0, 32'd0);
        @(negedge clk);
        wr(4'h3, 32'd0);
        check("t3_i_rev0", {31'd0, I}, 32'd1);
        wr(4'h0, 32'd1);
        wait_ab(20, n, ch);
        check("t3_rev_gap", n, 32'd9);
        check("t3_i_rev7", {31'd0, I}, 32'd0);
        rd_chk("t3_rev_pos", 4'h3, 32'hFFFF_FFFF);
        wr(4'h0, 32'd0);
`else
        // Index disabled: CPR reads 0, I stays low
        wr(4'h4, 32'd8);
        rd_chk("noidx_cpr", 4'h4, 32'd0);
        wr(4'h1, 32'd2);
        wr(4'h0, 32'd5);
        for (int i = 0; i < 3; i++) begin
            wait_ab(20, n, ch);
            check("noidx_i", {31'd0, I}, 32'd0);
        end
        wr(4'h0, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
